// File: rtl/axi_mm2s_arbiter.sv
// axi_mm2s_arbiter: round-robin sharing of one axi_mm2s read engine between
// C_NUM_REQ requesters. One command in flight; the engine status is routed
// back to the requester that issued the command.
// Optional build macro: AXI_MM2S_ARB_STATS_EN adds per-requester completion
// counters on stat_count.
//
// state   | meaning
// IDLE    | pick next requester round-robin, latch its command
// CMD     | present command to engine until accepted
// WAIT_ST | wait for the engine completion status
// RET     | present status to the owning requester until accepted
module axi_mm2s_arbiter #(
  parameter int C_NUM_REQ        = 4,
  parameter int C_AXI_ADDR_WIDTH = 64,
  localparam int C_ID_W          = $clog2(C_NUM_REQ)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [C_NUM_REQ*(C_AXI_ADDR_WIDTH+16)-1:0] s_req_tdata,
  input  logic [C_NUM_REQ-1:0]                       s_req_tvalid,
  output logic [C_NUM_REQ-1:0]                       s_req_tready,
  output logic [C_AXI_ADDR_WIDTH+15:0]               m_axis_ctl_tdata,
  output logic                                       m_axis_ctl_tvalid,
  input  logic                                       m_axis_ctl_tready,
  input  logic [7:0]                                 s_axis_st_tdata,
  input  logic                                       s_axis_st_tvalid,
  output logic                                       s_axis_st_tready,
  output logic [7:0]                                 m_st_tdata,
  output logic [C_NUM_REQ-1:0]                       m_st_tvalid,
  input  logic [C_NUM_REQ-1:0]                       m_st_tready,
  output logic                                       busy,
  output logic [C_ID_W-1:0]                          grant_id
`ifdef AXI_MM2S_ARB_STATS_EN
  ,
  output logic [C_NUM_REQ*32-1:0]                    stat_count
`endif
);

  localparam int CW = C_AXI_ADDR_WIDTH + 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RET  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cmd_q, cmd_d;
  logic [7:0]        st_q, st_d;
  logic [C_ID_W-1:0] grant_q, grant_d;

  logic [CW-1:0]     req_cmd [C_NUM_REQ];
  logic              win_found;
  logic [C_ID_W-1:0] win_id;
  logic [C_ID_W-1:0] idx;
  logic              ret_done;

  for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_unpack
    assign req_cmd[g] = s_req_tdata[g*CW +: CW];
  end

  // Round-robin winner: scan from grant_q+N down to grant_q+1 so the nearest
  // requester after the last grant is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_id    = grant_q;
    idx       = '0;
    for (int k = C_NUM_REQ; k >= 1; k--) begin
      idx = C_ID_W'((int'(grant_q) + k) % C_NUM_REQ);
      if (s_req_tvalid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign ret_done = (state_q == S_RET) && m_st_tready[grant_q];

  // Next-state and datapath for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    st_d    = st_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_id;
          cmd_d   = req_cmd[win_id];
          // Zero-length commands never reach the engine; answer them locally.
          if (req_cmd[win_id][CW-1:C_AXI_ADDR_WIDTH] == 16'd0) begin
            st_d    = 8'hFF;
            state_d = S_RET;
          end else begin
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (m_axis_ctl_tready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (s_axis_st_tvalid) begin
          st_d    = s_axis_st_tdata;
          state_d = S_RET;
        end
      end
      default: begin
        if (ret_done) state_d = S_IDLE;
      end
    endcase
  end

  // State registers; grant_q resets to the last slot so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      st_q    <= '0;
      grant_q <= C_ID_W'(C_NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      st_q    <= st_d;
      grant_q <= grant_d;
    end
  end

  // One-hot handshake outputs toward the requesters.
  always_comb begin
    s_req_tready = '0;
    m_st_tvalid  = '0;
    if ((state_q == S_IDLE) && win_found) s_req_tready[win_id] = 1'b1;
    if (state_q == S_RET) m_st_tvalid[grant_q] = 1'b1;
  end

  assign m_axis_ctl_tdata  = cmd_q;
  assign m_axis_ctl_tvalid = (state_q == S_CMD);
  assign s_axis_st_tready  = (state_q == S_WAIT);
  assign m_st_tdata        = st_q;
  assign busy              = (state_q != S_IDLE);
  assign grant_id          = grant_q;

`ifdef AXI_MM2S_ARB_STATS_EN
  logic [31:0] cnt_q [C_NUM_REQ];

  // Completed returns per requester; free-running, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (ret_done) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_stat
    assign stat_count[g*32 +: 32] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axi_mm2s_arbiter.sv
// Directed bench for axi_mm2s_arbiter (4 requesters, 64-bit addresses).
module tb_axi_mm2s_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [319:0] req_data = '0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [79:0]  ctl_data;
  logic         ctl_valid;
  logic         ctl_ready = 1'b0;
  logic [7:0]   st_data = '0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [7:0]   ret_data;
  logic [3:0]   ret_valid;
  logic [3:0]   ret_ready = '0;
  logic         busy;
  logic [1:0]   grant_id;
`ifdef AXI_MM2S_ARB_STATS_EN
  logic [127:0] stat_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_mm2s_arbiter #(.C_NUM_REQ(4), .C_AXI_ADDR_WIDTH(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_req_tdata       (req_data),
    .s_req_tvalid      (req_valid),
    .s_req_tready      (req_ready),
    .m_axis_ctl_tdata  (ctl_data),
    .m_axis_ctl_tvalid (ctl_valid),
    .m_axis_ctl_tready (ctl_ready),
    .s_axis_st_tdata   (st_data),
    .s_axis_st_tvalid  (st_valid),
    .s_axis_st_tready  (st_ready),
    .m_st_tdata        (ret_data),
    .m_st_tvalid       (ret_valid),
    .m_st_tready       (ret_ready),
    .busy              (busy),
    .grant_id          (grant_id)
`ifdef AXI_MM2S_ARB_STATS_EN
    ,
    .stat_count        (stat_count)
`endif
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [15:0] l, input logic v);
    req_data[i*80 +: 80] = {l, a};
    req_valid[i]         = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One full command: expects requester id to win at the current IDLE cycle.
  task automatic do_cmd(input int id, input logic [63:0] a, input logic [15:0] l,
                        input logic [7:0] st, input int ctl_stall, input int ret_stall);
    logic [3:0] oh;
    oh = 4'(1 << id);
    #1;
    check("grant_ready", 96'(req_ready), 96'(oh));
    tick();
    check("grant_id", 96'(grant_id), 96'(id));
    if (l != 16'd0) begin
      check("ctl_valid", 96'(ctl_valid), 96'd1);
      check("ctl_data", 96'(ctl_data), 96'({l, a}));
      for (int c = 0; c < ctl_stall; c++) begin
        tick();
        check("ctl_hold_valid", 96'(ctl_valid), 96'd1);
        check("ctl_hold_data", 96'(ctl_data), 96'({l, a}));
      end
      ctl_ready = 1'b1;
      tick();
      ctl_ready = 1'b0;
      check("ctl_no_dup", 96'(ctl_valid), 96'd0);
      check("st_ready", 96'(st_ready), 96'd1);
      st_valid = 1'b1;
      st_data  = st;
      tick();
      st_valid = 1'b0;
      st_data  = 8'h5A;
      check("st_ready_drop", 96'(st_ready), 96'd0);
    end else begin
      check("zero_len_no_ctl", 96'(ctl_valid), 96'd0);
    end
    check("ret_valid", 96'(ret_valid), 96'(oh));
    check("ret_data", 96'(ret_data), 96'(l == 16'd0 ? 8'hFF : st));
    for (int c = 0; c < ret_stall; c++) begin
      ret_ready = ~oh;
      tick();
      check("ret_hold_valid", 96'(ret_valid), 96'(oh));
      check("ret_hold_data", 96'(ret_data), 96'(l == 16'd0 ? 8'hFF : st));
    end
    ret_ready = oh;
    tick();
    ret_ready = '0;
    check("ret_done_busy", 96'(busy), 96'd0);
    check("ret_done_valid", 96'(ret_valid), 96'd0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_grant", 96'(grant_id), 96'd3);
    check("rst_ctl_valid", 96'(ctl_valid), 96'd0);
    check("rst_st_ready", 96'(st_ready), 96'd0);
    check("rst_ret_valid", 96'(ret_valid), 96'd0);
    check("rst_ret_data", 96'(ret_data), 96'd0);
    check("rst_req_ready", 96'(req_ready), 96'd0);

    // Single request from requester 0.
    set_req(0, 64'h1000, 16'd64, 1'b1);
    #1;
    check("t1_ready", 96'(req_ready), 96'b0001);
    tick();
    set_req(0, 64'h0, 16'd0, 1'b0);
    #1;
    check("t1_ready_one_cycle", 96'(req_ready), 96'd0);
    check("t1_busy", 96'(busy), 96'd1);
    check("t1_ctl_data", 96'(ctl_data), 96'({16'd64, 64'h1000}));
    check("t1_ctl_valid", 96'(ctl_valid), 96'd1);
    ctl_ready = 1'b1;
    tick();
    ctl_ready = 1'b0;
    st_valid  = 1'b1;
    st_data   = 8'h00;
    tick();
    st_valid  = 1'b0;
    check("t1_ret_valid", 96'(ret_valid), 96'b0001);
    check("t1_ret_data", 96'(ret_data), 96'h00);
    ret_ready = 4'b0001;
    tick();
    ret_ready = '0;
    check("t1_idle", 96'(busy), 96'd0);

    // All four requesters held valid: strict rotation from requester 0.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 64'h2000 + 64'(i * 256), 16'(16 * (i + 1)), 1'b1);
    for (int k = 0; k < 8; k++)
      do_cmd(k % 4, 64'h2000 + 64'((k % 4) * 256), 16'(16 * ((k % 4) + 1)), 8'(8'h10 + k), 0, 0);
    req_valid = '0;

    // Back-pressure on both sides for requester 2; non-owner ready ignored.
    set_req(2, 64'h3000, 16'd128, 1'b1);
    do_cmd(2, 64'h3000, 16'd128, 8'h02, 5, 3);
    req_valid = '0;

    // Zero-length command from requester 1.
    set_req(1, 64'h4000, 16'd0, 1'b1);
    do_cmd(1, 64'h4000, 16'd0, 8'h00, 0, 0);
    req_valid = '0;

    // Status presented early is not accepted while still in CMD.
    set_req(0, 64'h5000, 16'd32, 1'b1);
    tick();
    req_valid = '0;
    st_valid  = 1'b1;
    #1;
    check("t5_early_st_ready", 96'(st_ready), 96'd0);
    ctl_ready = 1'b1;
    tick();
    ctl_ready = 1'b0;
    st_valid  = 1'b0;
    check("t5_wait", 96'(st_ready), 96'd1);
    // Reset while waiting for status.
    do_reset();
    check("t5_rst_busy", 96'(busy), 96'd0);
    check("t5_rst_grant", 96'(grant_id), 96'd3);
    check("t5_rst_ctl_valid", 96'(ctl_valid), 96'd0);
    check("t5_rst_st_ready", 96'(st_ready), 96'd0);
    check("t5_rst_ret_valid", 96'(ret_valid), 96'd0);
    set_req(3, 64'h6300, 16'd8, 1'b1);
    set_req(0, 64'h6000, 16'd4, 1'b1);
    do_cmd(0, 64'h6000, 16'd4, 8'h60, 0, 0);
    set_req(0, 64'h0, 16'd0, 1'b0);
    do_cmd(3, 64'h6300, 16'd8, 8'h63, 1, 0);
    req_valid = '0;

`ifdef AXI_MM2S_ARB_STATS_EN
    do_reset();
    check("st_rst_clear", 96'(stat_count), 96'd0);
    set_req(1, 64'h7000, 16'd16, 1'b1);
    do_cmd(1, 64'h7000, 16'd16, 8'h71, 0, 1);
    do_cmd(1, 64'h7000, 16'd16, 8'h72, 0, 0);
    set_req(1, 64'h7000, 16'd0, 1'b1);
    do_cmd(1, 64'h7000, 16'd0, 8'h00, 0, 2);
    req_valid = '0;
    set_req(3, 64'h7300, 16'd16, 1'b1);
    do_cmd(3, 64'h7300, 16'd16, 8'h73, 0, 0);
    req_valid = '0;
    check("stat_slot0", 96'(stat_count[31:0]), 96'd0);
    check("stat_slot1", 96'(stat_count[63:32]), 96'd3);
    check("stat_slot2", 96'(stat_count[95:64]), 96'd0);
    check("stat_slot3", 96'(stat_count[127:96]), 96'd1);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
